// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states,
// per-stage stall vectors and the stall priority selector.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  function automatic logic [5:0] stall_sel(input logic flush_r, input logic mem_r,
                                           input logic ex_r, input logic id_r);
    if (flush_r)   return STALL_NONE;
    else if (mem_r) return STALL_MEM;
    else if (ex_r)  return STALL_EX;
    else if (id_r)  return STALL_ID;
    else            return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Free-running up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: arbitrates ID/EX/MEM stall requests and
// tracks outstanding data-memory accesses with a bounded wait.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        dmem_en,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_hit;
  logic             mem_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !flush_req) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        // flush abandons the access silently; ready beats a same-cycle timeout
        if (flush_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (mem_ready) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          to_hit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_stall   = ((state_q == ST_IDLE) && mem_req) || (state_q == ST_BUSY);
  assign stall       = rst ? STALL_NONE : stall_sel(flush_req, mem_stall, stallreq_ex, stallreq_id);
  assign flush       = !rst && flush_req;
  assign dmem_en     = !rst && (((state_q == ST_IDLE) && mem_req && !flush_req) ||
                                (state_q == ST_BUSY));
  assign mem_timeout = !rst && to_hit;

  sat_counter #(.W(32)) u_stall_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (|stall),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, stallreq_ex, mem_req, mem_ready, flush_req;
  logic [5:0]  stall;
  logic        flush, dmem_en, mem_timeout;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .dmem_en      (dmem_en),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: is a memory access outstanding, how many wait cycles
  // have already passed, and did the access just finish.
  bit      m_waiting = 0;
  bit      m_finishing = 0;
  int      m_waited = 0;
  longint  m_stall_total = 0;

  function automatic logic [5:0] exp_stall();
    if (rst || flush_req) return 6'd0;
    if ((!m_waiting && !m_finishing && mem_req) || m_waiting) return 6'b011111;
    if (stallreq_ex) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'd0;
  endfunction

  always @(negedge clk) begin : compare
    logic [5:0] es;
    logic       edmem, eto;
    logic [31:0] esc;
    es    = exp_stall();
    edmem = !rst && (m_waiting || (!m_waiting && !m_finishing && mem_req && !flush_req));
    eto   = !rst && m_waiting && !flush_req && !mem_ready && (m_waited + 1 >= TO);
    esc   = (m_stall_total > 64'hFFFFFFFF) ? 32'hFFFFFFFF : m_stall_total[31:0];
    chk("m_stall", {26'd0, stall}, {26'd0, es});
    chk("m_flush", {31'd0, flush}, {31'd0, !rst && flush_req});
    chk("m_dmem_en", {31'd0, dmem_en}, {31'd0, edmem});
    chk("m_timeout", {31'd0, mem_timeout}, {31'd0, eto});
    chk("m_stall_cycles", stall_cycles, esc);
    // advance the model to what the next rising edge produces
    if (rst) begin
      m_waiting = 0; m_finishing = 0; m_waited = 0; m_stall_total = 0;
    end else begin
      if (es != 0) m_stall_total++;
      if (m_finishing) begin
        m_finishing = 0;
      end else if (m_waiting) begin
        if (flush_req) begin
          m_waiting = 0;
        end else if (mem_ready || eto) begin
          m_waiting = 0; m_finishing = 1;
        end else begin
          m_waited++;
        end
      end else if (mem_req && !flush_req) begin
        m_waiting = 1; m_waited = 0;
      end
    end
  end

  task automatic step(input logic r, input logic id, input logic ex,
                      input logic mq, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex;
    mem_req = mq; mem_ready = mr; flush_req = fl;
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stallreq_id = 1; stallreq_ex = 1; mem_req = 1; mem_ready = 1; flush_req = 1;

    // reset with every input asserted
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 1, 1, 1);
      chk("rst_stall", {26'd0, stall}, 32'h0);
      chk("rst_flush", {31'd0, flush}, 32'h0);
      chk("rst_dmem", {31'd0, dmem_en}, 32'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_cycles", stall_cycles, 32'd0);

    // load acknowledged in the third wait cycle
    step(0, 0, 0, 1, 0, 0);
    chk("ld_idle_stall", {26'd0, stall}, 32'h1F);
    chk("ld_idle_dmem", {31'd0, dmem_en}, 32'h1);
    step(0, 0, 0, 1, 0, 0);
    chk("ld_b1_stall", {26'd0, stall}, 32'h1F);
    step(0, 0, 0, 1, 0, 0);
    chk("ld_b2_stall", {26'd0, stall}, 32'h1F);
    step(0, 0, 0, 1, 1, 0);
    chk("ld_b3_stall", {26'd0, stall}, 32'h1F);
    chk("ld_b3_to", {31'd0, mem_timeout}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("ld_done_stall", {26'd0, stall}, 32'h0);
    chk("ld_done_dmem", {31'd0, dmem_en}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("ld_cycles", stall_cycles, 32'd4);

    // timeout after TO wait cycles
    step(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= TO; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("to_busy_stall", {26'd0, stall}, 32'h1F);
      chk("to_pulse", {31'd0, mem_timeout}, (i == TO) ? 32'h1 : 32'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("to_done_pulse", {31'd0, mem_timeout}, 32'h0);
    chk("to_done_dmem", {31'd0, dmem_en}, 32'h0);
    step(0, 0, 0, 0, 0, 0);

    // stall priority mem > ex > id
    step(0, 1, 1, 1, 0, 0);
    chk("pri_mem", {26'd0, stall}, 32'h1F);
    step(0, 1, 1, 0, 1, 0);
    chk("pri_busy", {26'd0, stall}, 32'h1F);
    step(0, 1, 1, 0, 0, 0);
    chk("pri_ex", {26'd0, stall}, 32'h0F);
    step(0, 1, 0, 0, 0, 0);
    chk("pri_id", {26'd0, stall}, 32'h07);

    // flush during the second wait cycle
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("fl_flush", {31'd0, flush}, 32'h1);
    chk("fl_stall", {26'd0, stall}, 32'h0);
    chk("fl_to", {31'd0, mem_timeout}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("fl_idle_dmem", {31'd0, dmem_en}, 32'h0);
    chk("fl_idle_flush", {31'd0, flush}, 32'h0);

    // back-to-back loads, each acknowledged in its first wait cycle
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("b2b_idle", {26'd0, stall}, 32'h1F);
      step(0, 0, 0, 1, 1, 0);
      chk("b2b_busy", {26'd0, stall}, 32'h1F);
      chk("b2b_busy_dmem", {31'd0, dmem_en}, 32'h1);
      step(0, 0, 0, 1, 0, 0);
      chk("b2b_done", {26'd0, stall}, 32'h0);
    end

    // reset in the middle of a wait
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rstb_to", {31'd0, mem_timeout}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstb_idle_stall", {26'd0, stall}, 32'h0);
    chk("rstb_cycles", stall_cycles, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 30), ($urandom_range(99) < 25),
           ($urandom_range(99) < 50), ($urandom_range(99) < 30), ($urandom_range(99) < 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
